// File: rtl/pc_load_sequencer_if.sv
// Bus between the program-counter load sequencer and its environment.
// Inputs:  data_in (operand byte), byte_valid, jump_req, cond, inc_req.
// Outputs: inQ (byte to both counter chips), RCKEN_HI_bar/RCKEN_LO_bar
//          (register-load enables), CLOAD_bar (counter load), CCKEN (count
//          enable), busy, done, err.
interface pc_load_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             byte_valid;
  logic             jump_req;
  logic             cond;
  logic             inc_req;
  logic [WIDTH-1:0] inQ;
  logic             RCKEN_HI_bar;
  logic             RCKEN_LO_bar;
  logic             CLOAD_bar;
  logic             CCKEN;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output data_in, byte_valid, jump_req, cond, inc_req,
    input  inQ, RCKEN_HI_bar, RCKEN_LO_bar, CLOAD_bar, CCKEN, busy, done, err
  );

  modport slave (
    input  data_in, byte_valid, jump_req, cond, inc_req,
    output inQ, RCKEN_HI_bar, RCKEN_LO_bar, CLOAD_bar, CCKEN, busy, done, err
  );
endinterface

// File: rtl/pc_load_sequencer.sv
// Control stage ahead of the two cascaded counter chips forming the 16-bit
// program counter. Collects two operand bytes on a jump, steers them into the
// high/low chip registers, then pulses the counter load (or skips it when the
// jump condition was false). Outside jumps, inc_req drives the count enable.
// Ports: CCK (clock), CCLR_bar (async active-low reset), bus (slave modport,
// see pc_load_sequencer_if). All outputs are registered.
module pc_load_sequencer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned HI_FIRST = 1,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                CCK,
  input  logic                CCLR_bar,
  pc_load_sequencer_if.slave  bus
);

  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {IDLE, BYTE1, BYTE2, LOAD} state_t;

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n, timer_inc;
  logic             taken, taken_n;
  logic [WIDTH-1:0] inq_q, inq_n;
  logic             rhi_q, rhi_n;
  logic             rlo_q, rlo_n;
  logic             cload_q, cload_n;
  logic             ccken_q, ccken_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             err_q, err_n;

  // State and output registers.
  always_ff @(posedge CCK or negedge CCLR_bar) begin
    if (!CCLR_bar) begin
      state   <= IDLE;
      timer   <= '0;
      taken   <= 1'b0;
      inq_q   <= '0;
      rhi_q   <= 1'b1;
      rlo_q   <= 1'b1;
      cload_q <= 1'b1;
      ccken_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      taken   <= taken_n;
      inq_q   <= inq_n;
      rhi_q   <= rhi_n;
      rlo_q   <= rlo_n;
      cload_q <= cload_n;
      ccken_q <= ccken_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // Next state and next registered outputs; strobes default to inactive.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    taken_n   = taken;
    inq_n     = inq_q;
    rhi_n     = 1'b1;
    rlo_n     = 1'b1;
    cload_n   = 1'b1;
    ccken_n   = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    timer_inc = (timer == '1) ? timer : timer + TW'(1);

    unique case (state)
      IDLE: begin
        if (bus.jump_req) begin
          taken_n = bus.cond;
          timer_n = '0;
          state_n = BYTE1;
        end else begin
          ccken_n = bus.inc_req;
        end
      end
      BYTE1, BYTE2: begin
        if (bus.byte_valid) begin
          inq_n   = bus.data_in;
          ccken_n = 1'b1;
          timer_n = '0;
          // Skipped jumps still consume operand bytes but never write them.
          if (taken) begin
            if ((state == BYTE1) == (HI_FIRST != 0)) rhi_n = 1'b0;
            else                                     rlo_n = 1'b0;
          end
          if (state == BYTE1) begin
            state_n = BYTE2;
          end else if (taken) begin
            state_n = LOAD;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else begin
          timer_n = timer_inc;
          if (32'(timer_inc) >= TIMEOUT) begin
            state_n = IDLE;
            timer_n = '0;
            err_n   = 1'b1;
          end
        end
      end
      LOAD: begin
        cload_n = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.inQ          = inq_q;
  assign bus.RCKEN_HI_bar = rhi_q;
  assign bus.RCKEN_LO_bar = rlo_q;
  assign bus.CLOAD_bar    = cload_q;
  assign bus.CCKEN        = ccken_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_pc_load_sequencer.sv
// Self-checking bench for pc_load_sequencer: directed scenarios followed by
// randomized traffic, compared each cycle against a transaction-level model.
module tb_pc_load_sequencer;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned HI_FIRST = 1;
  localparam int unsigned TIMEOUT  = 15;

  logic CCK = 1'b0;
  logic CCLR_bar = 1'b0;
  always #5 CCK = ~CCK;

  pc_load_sequencer_if #(.WIDTH(WIDTH)) bus ();

  pc_load_sequencer #(.WIDTH(WIDTH), .HI_FIRST(HI_FIRST), .TIMEOUT(TIMEOUT)) dut (
    .CCK      (CCK),
    .CCLR_bar (CCLR_bar),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: tracks a jump as "bytes collected so far" plus a wait count.
  bit             m_busy;
  int             m_nbytes;
  int             m_wait;
  bit             m_take;
  logic [WIDTH-1:0] e_inq;
  logic e_rhi, e_rlo, e_cload, e_ccken, e_busy, e_done, e_err;

  int cnt_ccken, cnt_rcken, cnt_cload, cnt_done, cnt_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_nbytes = 0; m_wait = 0; m_take = 0;
    e_inq = '0; e_rhi = 1; e_rlo = 1; e_cload = 1;
    e_ccken = 0; e_busy = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_step();
    e_rhi = 1; e_rlo = 1; e_cload = 1; e_ccken = 0; e_done = 0; e_err = 0;
    if (!m_busy) begin
      if (bus.jump_req) begin
        m_busy = 1; m_nbytes = 0; m_wait = 0; m_take = bus.cond;
      end else begin
        e_ccken = bus.inc_req;
      end
    end else if (m_nbytes == 2) begin
      e_cload = 0; e_done = 1; m_busy = 0;
    end else if (bus.byte_valid) begin
      e_inq = bus.data_in;
      e_ccken = 1;
      if (m_take) begin
        if ((m_nbytes == 0) == (HI_FIRST == 1)) e_rhi = 0;
        else                                    e_rlo = 0;
      end
      m_nbytes++;
      m_wait = 0;
      if (m_nbytes == 2 && !m_take) begin
        e_done = 1; m_busy = 0;
      end
    end else begin
      m_wait++;
      if (m_wait >= TIMEOUT) begin
        e_err = 1; m_busy = 0;
      end
    end
    e_busy = m_busy;
  endtask

  task automatic compare();
    int lows;
    check("inQ", 32'(bus.inQ), 32'(e_inq));
    check("strobes", {28'd0, bus.RCKEN_HI_bar, bus.RCKEN_LO_bar, bus.CLOAD_bar, bus.CCKEN},
          {28'd0, e_rhi, e_rlo, e_cload, e_ccken});
    check("flags", {29'd0, bus.busy, bus.done, bus.err}, {29'd0, e_busy, e_done, e_err});
    lows = int'(!bus.RCKEN_HI_bar) + int'(!bus.RCKEN_LO_bar) + int'(!bus.CLOAD_bar);
    check("exclusive", 32'((lows > 1) || (bus.CCKEN && !bus.CLOAD_bar)), 32'd0);
    cnt_ccken += int'(bus.CCKEN === 1'b1);
    cnt_rcken += int'(!bus.RCKEN_HI_bar) + int'(!bus.RCKEN_LO_bar);
    cnt_cload += int'(bus.CLOAD_bar === 1'b0);
    cnt_done  += int'(bus.done === 1'b1);
    cnt_err   += int'(bus.err === 1'b1);
  endtask

  task automatic clear_counts();
    cnt_ccken = 0; cnt_rcken = 0; cnt_cload = 0; cnt_done = 0; cnt_err = 0;
  endtask

  // Drive one cycle of inputs, clock it, then check outputs just after the edge.
  task automatic cycle(input logic jr, input logic c, input logic bv, input logic ir,
                       input logic [WIDTH-1:0] d);
    bus.jump_req = jr; bus.cond = c; bus.byte_valid = bv; bus.inc_req = ir; bus.data_in = d;
    @(posedge CCK);
    model_step();
    #1 compare();
  endtask

  // Asynchronous reset mid-cycle; byte_valid held during reset must do nothing.
  task automatic async_reset();
    #2 CCLR_bar = 1'b0;
    #1;
    model_reset();
    compare();
    bus.jump_req = 0; bus.byte_valid = 1; bus.data_in = WIDTH'($urandom);
    @(posedge CCK);
    #1 compare();
    CCLR_bar = 1'b1;
  endtask

  int quiet;

  initial begin
    bus.jump_req = 0; bus.cond = 0; bus.byte_valid = 0; bus.inc_req = 0; bus.data_in = '0;
    model_reset();
    clear_counts();
    repeat (3) @(posedge CCK);
    #1 compare();
    CCLR_bar = 1'b1;

    // inc_req for three cycles.
    clear_counts();
    repeat (3) cycle(0, 0, 0, 1, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    check("inc_ccken_count", 32'(cnt_ccken), 32'd3);

    // Taken jump, high byte first.
    clear_counts();
    cycle(1, 1, 0, 1, 8'h00);
    cycle(0, 0, 1, 0, 8'h12);
    check("taken_byte1", {23'd0, bus.inQ, bus.RCKEN_HI_bar}, {23'd0, 8'h12, 1'b0});
    cycle(0, 0, 1, 0, 8'h34);
    check("taken_byte2", {23'd0, bus.inQ, bus.RCKEN_LO_bar}, {23'd0, 8'h34, 1'b0});
    cycle(0, 0, 0, 0, 8'h00);
    check("taken_load", {30'd0, bus.CLOAD_bar, bus.done}, {30'd0, 1'b0, 1'b1});
    cycle(0, 0, 0, 0, 8'h00);
    check("taken_ccken_count", 32'(cnt_ccken), 32'd2);
    check("taken_cload_count", 32'(cnt_cload), 32'd1);

    // Skipped jump.
    clear_counts();
    cycle(1, 0, 0, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h12);
    cycle(0, 0, 1, 0, 8'h34);
    check("skip_done", 32'(bus.done), 32'd1);
    cycle(0, 0, 0, 0, 8'h00);
    check("skip_counts", {8'(cnt_rcken), 8'(cnt_cload), 8'(cnt_ccken), 8'(cnt_done)},
          {8'd0, 8'd0, 8'd2, 8'd1});

    // Timeout waiting for the second byte.
    clear_counts();
    cycle(1, 1, 0, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'hAB);
    repeat (TIMEOUT) cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    check("timeout_counts", {8'(cnt_err), 8'(cnt_cload), 8'(cnt_done), 7'd0, bus.busy},
          {8'd1, 8'd0, 8'd0, 8'd0});

    // Reset between the two register strobes.
    clear_counts();
    cycle(1, 1, 0, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h12);
    async_reset();
    clear_counts();
    cycle(0, 0, 1, 0, 8'h34);
    cycle(0, 0, 0, 0, 8'h00);
    check("post_reset_strobes", {8'(cnt_rcken), 8'(cnt_cload), 8'(cnt_ccken), 8'd0}, 32'd0);

    // jump_req while busy and byte_valid in idle are ignored.
    clear_counts();
    cycle(1, 1, 0, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h56);
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 1, 1, 0, 8'h78);
    cycle(0, 0, 1, 0, 8'h9A);
    cycle(0, 0, 1, 0, 8'hBC);
    cycle(0, 0, 0, 0, 8'h00);
    check("busy_ignore_counts", {8'(cnt_done), 8'(cnt_cload), 8'(cnt_rcken), 7'd0, bus.busy},
          {8'd1, 8'd1, 8'd2, 8'd0});
    check("idle_byte_inq", 32'(bus.inQ), 32'h78);

    // Randomized traffic with occasional quiet stretches and resets.
    quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      logic bv;
      if (quiet == 0 && $urandom_range(0, 40) == 0) quiet = $urandom_range(5, 20);
      bv = (quiet > 0) ? 1'b0 : 1'($urandom_range(0, 2) != 0);
      if (quiet > 0) quiet--;
      if ($urandom_range(0, 499) == 0) async_reset();
      else cycle(1'($urandom_range(0, 5) == 0), 1'($urandom), bv, 1'($urandom), WIDTH'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_load_sequencer.md
Name: pc_load_sequencer

Overview:
- Control stage directly upstream of the two cascaded 8-bit counter/register chips (high and low bytes) that form the 16-bit program counter.
- On a jump request it collects two operand bytes from the data bus and steers each into the matching chip's input register.
- It then pulses the counter load strobe, or skips the load when the condition is false.
- Outside jumps it turns the fetch-increment request into the counters' count enable.

Parameters:
- WIDTH, 8, byte width of the data bus and of each counter chip.
- HI_FIRST, 1, operand byte order: 1 = high byte first, 0 = low byte first.
- TIMEOUT, 15, number of cycles to wait for each operand byte before aborting (1..255).

Ports:
- CCK  input  1  system clock; all state changes on the rising edge.
- CCLR_bar  input  1  reset, asynchronous, active-low.
- data_in  input  WIDTH  operand byte from the data bus.
- byte_valid  input  1  data_in holds an operand byte this cycle.
- jump_req  input  1  start a jump sequence; sampled only in IDLE.
- cond  input  1  jump condition, sampled together with jump_req.
- inc_req  input  1  fetch-increment request; honoured only in IDLE.
- inQ  output  WIDTH  registered byte driven to both counter chips' register inputs.
- RCKEN_HI_bar  output  1  active-low register-load enable, high-byte chip.
- RCKEN_LO_bar  output  1  active-low register-load enable, low-byte chip.
- CLOAD_bar  output  1  active-low counter load (register to counter), common to both chips.
- CCKEN  output  1  counter count enable.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when a sequence completes, whether the jump was taken or skipped.
- err  output  1  one-cycle pulse when a sequence aborts on timeout.

Behaviour:
- Reset (CCLR_bar low) is asynchronous and immediate, including mid-sequence. Reset values:
  - state IDLE, timer 0, taken flag 0;
  - inQ = 0;
  - RCKEN_HI_bar = 1, RCKEN_LO_bar = 1, CLOAD_bar = 1;
  - CCKEN = 0, busy = 0, done = 0, err = 0.
- All outputs are registered: each output reflects the decision made at the previous rising CCK edge.
- States: IDLE, BYTE1, BYTE2, LOAD.
- IDLE:
  - CCKEN follows inc_req with one cycle of latency.
  - byte_valid is ignored.
  - If jump_req = 1: latch cond into the taken flag, clear the timer, go to BYTE1. CCKEN = 0 on that edge, even if inc_req = 1 (jump_req wins).
- BYTE1 and BYTE2:
  - On byte_valid: inQ <= data_in. Pulse the correct RCKEN for one cycle: in BYTE1 use the high-byte enable when HI_FIRST = 1, otherwise the low-byte enable; BYTE2 uses the other one.
  - Also pulse CCKEN for one cycle so the program counter steps past the operand byte.
  - Then clear the timer and advance. BYTE1 goes to BYTE2. BYTE2 goes to LOAD if taken = 1; if taken = 0 it goes to IDLE with done pulsed.
  - If taken = 0, the RCKEN pulses are suppressed: operand bytes are consumed and counted but never written.
  - Without byte_valid: the timer increments. When it reaches TIMEOUT, go to IDLE, pulse err, and emit no further strobes. Register contents already written are left as they are.
- LOAD:
  - CLOAD_bar low for exactly one cycle, CCKEN = 0, done pulsed.
  - Next state IDLE; inc_req is honoured again from the following cycle.
- Latency, taken jump: jump_req edge, then at least 2 operand edges, then CLOAD_bar asserted on the edge after the second byte. Minimum 4 cycles from jump_req to the return to IDLE.
- jump_req while busy is ignored; no queuing.
- byte_valid on the same edge that enters BYTE1 is not consumed; it is first sampled in BYTE1.
- At most one of RCKEN_HI_bar, RCKEN_LO_bar, CLOAD_bar is low in any cycle. CCKEN is never high while CLOAD_bar is low.
- The timer is 8 bits wide, saturates, and restarts for each byte.
- inQ holds its last value between writes; it changes only on accepted bytes.

Test Plan:
- Reset, then inc_req = 1 for 3 cycles -> CCKEN high for 3 cycles, starting one cycle later; all strobes inactive; busy = 0.
- HI_FIRST = 1, jump_req with cond = 1, then bytes 0x12 and 0x34 on consecutive cycles:
  - inQ = 0x12 with RCKEN_HI_bar low;
  - then inQ = 0x34 with RCKEN_LO_bar low;
  - then CLOAD_bar low with done = 1;
  - CCKEN pulsed exactly twice.
- Same sequence with cond = 0 -> RCKEN_* never low, CLOAD_bar never low, CCKEN pulsed twice, done pulsed after the second byte.
- jump_req, first byte 0xAB, then no byte_valid for TIMEOUT = 15 cycles -> err pulses once, state returns to IDLE, CLOAD_bar never low, busy falls.
- CCLR_bar driven low between RCKEN_HI_bar and RCKEN_LO_bar of a taken jump -> all outputs at reset values within the same cycle (asynchronously); a subsequent byte_valid produces no strobes.
- jump_req re-asserted while in BYTE2, and byte_valid with jump_req = 0 in IDLE -> both ignored; only one done pulse per sequence.
